// File: rtl/rom_stream_reader.sv
// rom_stream_reader
//   Address sequencer and 2-entry output buffer placed directly in front of a
//   synchronous ROM with 1-cycle read latency. A run of 'count' words starting
//   at 'base_addr' is read from the ROM and presented as a valid/ready stream.
//   The final word of the run is flagged with out_last.
//
// Ports
//   clk, rst_n           clock (rising edge), async active-low reset
//   start                one-cycle run request, sampled only while idle
//   base_addr, count     run parameters, captured with start
//   busy, done           run in progress / one-cycle completion pulse
//   rom_en, rom_addr     ROM read port
//   rom_data             ROM read data, valid one cycle after rom_en
//   out_valid, out_data,
//   out_last, out_ready  downstream stream
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; captures base_addr/count
// RUN   | issuing ROM reads and draining the buffer
// DONE  | one-cycle done pulse, then back to IDLE
module rom_stream_reader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   count,
  output logic                  busy,
  output logic                  done,
  output logic                  rom_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic [ADDR_WIDTH:0]   issued;
  logic [ADDR_WIDTH:0]   popped;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] buf0;
  logic [DATA_WIDTH-1:0] buf1;
  logic [1:0]            buf_cnt;
  logic                  pop;
  logic                  push;
  logic                  credit_ok;
  logic                  issue;
  logic                  last_pop;

  assign out_valid = (buf_cnt != 2'd0);
  assign out_data  = buf0;
  assign pop       = out_valid && out_ready;
  assign push      = inflight;

  // Words already buffered plus the one in flight must leave room for the
  // new read; a pop in this same cycle frees one slot.
  assign credit_ok = ({1'b0, buf_cnt} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
  assign issue     = (state == RUN) && (issued < count_q) && credit_ok;

  assign rom_en    = issue;
  assign rom_addr  = issue ? (base_q + issued[ADDR_WIDTH-1:0]) : addr_q;

  assign out_last  = out_valid && (popped == (count_q - ONE));
  assign last_pop  = pop && (popped == (count_q - ONE));

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      base_q   <= '0;
      addr_q   <= '0;
      count_q  <= '0;
      issued   <= '0;
      popped   <= '0;
      inflight <= 1'b0;
      buf0     <= '0;
      buf1     <= '0;
      buf_cnt  <= 2'd0;
    end else begin
      inflight <= issue;

      if (issue) begin
        issued <= issued + ONE;
        addr_q <= rom_addr;
      end
      if (pop) popped <= popped + ONE;

      // Head (buf0) always feeds the stream; a pop shifts buf1 forward.
      unique case ({push, pop})
        2'b10: begin
          if (buf_cnt == 2'd0) buf0 <= rom_data;
          else                 buf1 <= rom_data;
          buf_cnt <= buf_cnt + 2'd1;
        end
        2'b01: begin
          buf0    <= buf1;
          buf_cnt <= buf_cnt - 2'd1;
        end
        2'b11: begin
          if (buf_cnt == 2'd1) begin
            buf0 <= rom_data;
          end else begin
            buf0 <= buf1;
            buf1 <= rom_data;
          end
        end
        default: ;
      endcase

      case (state)
        IDLE: begin
          if (start) begin
            base_q  <= base_addr;
            count_q <= count;
            issued  <= '0;
            popped  <= '0;
            state   <= (count != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (last_pop) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_stream_reader.sv
module tb_rom_stream_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] base_addr;
  logic [4:0] count;
  logic       busy, done, rom_en;
  logic [3:0] rom_addr;
  logic [7:0] rom_data;
  logic       out_valid, out_last, out_ready;
  logic [7:0] out_data;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [16];

  // stream capture state
  logic [7:0] got_data [32];
  bit         got_last [32];
  int         n_got, iss, done_cyc, en_cnt, valid_cnt;
  int         credit_viol, stall_viol, addr_viol, max_occ;
  bit         done_seen;
  logic [7:0] data_c9;

  always #5 clk = ~clk;

  always @(posedge clk) if (rom_en) rom_data <= mem[rom_addr];

  rom_stream_reader #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .count(count), .busy(busy), .done(done), .rom_en(rom_en),
    .rom_addr(rom_addr), .rom_data(rom_data), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_ready(out_ready)
  );

  function automatic logic ready_for(input int mode, input int cyc);
    if (mode == 1) return !(cyc >= 3 && cyc <= 9);
    if (mode == 2) return logic'($urandom_range(0, 1));
    return 1'b1;
  endfunction

  // Drives one run and records what the stream delivered; the scenario tasks
  // judge the records. start is high in cycle 0; extra_start injects a second
  // start pulse (with different parameters) in that cycle number.
  task automatic run_stream(input logic [3:0] b, input logic [4:0] c,
                            input int mode, input int extra_start);
    bit         prev_stall = 0;
    logic [7:0] prev_data  = '0;
    logic       prev_last  = 0;
    int         occ;
    @(posedge clk); #1;
    base_addr = b; count = c; start = 1'b1; out_ready = ready_for(mode, 0);
    n_got = 0; iss = 0; done_seen = 0; done_cyc = -1; en_cnt = 0; valid_cnt = 0;
    credit_viol = 0; stall_viol = 0; addr_viol = 0; max_occ = 0; data_c9 = 'x;
    for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
      @(negedge clk);
      if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last))
        stall_viol++;
      occ = iss - n_got;
      if (occ > max_occ) max_occ = occ;
      if (rom_en) begin
        en_cnt++;
        if (occ >= 2 + ((out_valid && out_ready) ? 1 : 0)) credit_viol++;
        if (rom_addr !== 4'((int'(b) + iss) % 16)) addr_viol++;
        iss++;
      end
      if (out_valid) valid_cnt++;
      if (cyc == 9) data_c9 = out_data;
      if (out_valid && out_ready && n_got < 32) begin
        got_data[n_got] = out_data;
        got_last[n_got] = out_last;
        n_got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (done) begin done_seen = 1; done_cyc = cyc; end
      @(posedge clk); #1;
      start = (cyc + 1 == extra_start);
      if (start) begin base_addr = 4'd9; count = 5'd3; end
      out_ready = ready_for(mode, cyc + 1);
    end
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; base_addr = 0; count = 0; out_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, rom_en, rom_addr, out_valid, out_data, out_last} !== 17'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0",
               {busy, done, rom_en, rom_addr, out_valid, out_data, out_last});
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic_timing();
    logic e_en, e_v, e_last, e_done, e_busy;
    @(posedge clk); #1;
    base_addr = 4'd2; count = 5'd4; start = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      e_en = (c >= 1 && c <= 4); e_v = (c >= 3 && c <= 6);
      e_last = (c == 6); e_done = (c == 7); e_busy = (c >= 1 && c <= 7);
      checks++;
      if ({rom_en, out_valid, out_last, done, busy} !== {e_en, e_v, e_last, e_done, e_busy}) begin
        failures++;
        $display("FAIL basic_ctrl cyc=%0d got en/v/last/done/busy=%b want=%b", c,
                 {rom_en, out_valid, out_last, done, busy}, {e_en, e_v, e_last, e_done, e_busy});
      end
      if (e_en) begin
        checks++;
        if (rom_addr !== 4'(c + 1)) begin
          failures++;
          $display("FAIL basic_addr cyc=%0d got=%0d want=%0d", c, rom_addr, c + 1);
        end
      end
      if (e_v) begin
        checks++;
        if (out_data !== mem[c - 1]) begin
          failures++;
          $display("FAIL basic_data cyc=%0d got=%h want=%h", c, out_data, mem[c - 1]);
        end
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic check_stream(input string name, input logic [3:0] b, input int c);
    checks++;
    if (n_got !== c || !done_seen) begin
      failures++;
      $display("FAIL %s_count got=%0d done=%0b want=%0d done=1", name, n_got, done_seen, c);
    end
    for (int i = 0; i < c && i < n_got; i++) begin
      checks++;
      if (got_data[i] !== mem[(int'(b) + i) % 16] || got_last[i] !== (i == c - 1)) begin
        failures++;
        $display("FAIL %s_word%0d got=%h last=%0b want=%h last=%0b", name, i,
                 got_data[i], got_last[i], mem[(int'(b) + i) % 16], i == c - 1);
      end
    end
    checks++;
    if (credit_viol != 0 || stall_viol != 0 || addr_viol != 0 || max_occ > 2 || iss != c) begin
      failures++;
      $display("FAIL %s_protocol got credit=%0d stall=%0d addr=%0d occ=%0d iss=%0d want 0/0/0/<=2/%0d",
               name, credit_viol, stall_viol, addr_viol, max_occ, iss, c);
    end
  endtask

  task automatic test_wrap();
    run_stream(4'd14, 5'd4, 0, -1);
    check_stream("wrap", 4'd14, 4);
    checks++;
    if (done_cyc != 7) begin
      failures++;
      $display("FAIL wrap_done_cycle got=%0d want=7", done_cyc);
    end
  endtask

  task automatic test_backpressure();
    run_stream(4'd0, 5'd8, 1, -1);
    check_stream("stall", 4'd0, 8);
    checks++;
    if (data_c9 !== mem[0]) begin
      failures++;
      $display("FAIL stall_hold got=%h want=%h", data_c9, mem[0]);
    end
  endtask

  task automatic test_count_zero();
    run_stream(4'd3, 5'd0, 0, -1);
    checks++;
    if (en_cnt != 0 || valid_cnt != 0 || done_cyc != 1) begin
      failures++;
      $display("FAIL zero_count got en=%0d valid=%0d done_cyc=%0d want 0/0/1",
               en_cnt, valid_cnt, done_cyc);
    end
  endtask

  task automatic test_back_to_back();
    run_stream(4'd0, 5'd16, 2, 5);
    check_stream("full", 4'd0, 16);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL full_idle_after got busy=%b want=0", busy);
    end
  endtask

  task automatic test_reset_mid_run();
    int seen = 0;
    @(posedge clk); #1;
    base_addr = 4'd0; count = 5'd8; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 50 && seen < 3; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) seen++;
    end
    checks++;
    if (seen != 3) begin
      failures++;
      $display("FAIL midrst_progress got=%0d want=3", seen);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, rom_en, rom_addr, out_valid, out_data, out_last} !== 17'd0) begin
      failures++;
      $display("FAIL midrst_outputs got=%h want=0",
               {busy, done, rom_en, rom_addr, out_valid, out_data, out_last});
    end
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    run_stream(4'd5, 5'd2, 0, -1);
    check_stream("midrst_fresh", 4'd5, 2);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'(i * 37 + 5);
    test_reset();
    test_basic_timing();
    test_wrap();
    test_backpressure();
    test_count_zero();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rom_stream_reader.md
Name: rom_stream_reader

Overview:
- Address sequencer and output buffer that sits directly upstream of the synchronous ROM. It drives the ROM's en/addr and consumes its 1-cycle-latency data.
- Reads a contiguous run of words (base address plus count) and presents them as a valid/ready stream with a last flag to the downstream compute/load stage.
- Absorbs ROM read latency and downstream backpressure with a 2-entry buffer, so no word is ever lost or duplicated.

Parameters:
- ADDR_WIDTH, 4, ROM address width; must match the attached ROM.
- DATA_WIDTH, 8, ROM word width; must match the attached ROM.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a run; sampled only when busy=0.
- base_addr  in  ADDR_WIDTH  first ROM address of the run; captured with start.
- count  in  ADDR_WIDTH+1  number of words to read, 0..2**ADDR_WIDTH; captured with start.
- busy  out  1  high from the cycle after start is accepted until the cycle done is asserted (inclusive).
- done  out  1  one-cycle pulse when the run is complete.
- rom_en  out  1  ROM read enable; connects to ROM en.
- rom_addr  out  ADDR_WIDTH  ROM read address; connects to ROM addr.
- rom_data  in  DATA_WIDTH  ROM output; valid one cycle after a rom_en cycle.
- out_valid  out  1  stream word valid.
- out_data  out  DATA_WIDTH  stream word.
- out_last  out  1  high with the final word of the run.
- out_ready  in  1  downstream accepts the word when out_valid && out_ready.

Behaviour:
- Reset (async assert, sync release): state IDLE; busy=0, done=0, rom_en=0, rom_addr=0, out_valid=0, out_data=0, out_last=0; buffer emptied; issue, pop and in-flight counters cleared.
- FSM states:
  - IDLE: start=1 at a clock edge captures base_addr/count. Next state is RUN if count>0, otherwise DONE.
  - RUN: issues reads and drains the buffer. Moves to DONE on the edge where the last word (pop count reaches count) handshakes.
  - DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
- start while busy=1 is ignored: no capture and no effect on the current run.
- Read issue (RUN only): rom_en=1 iff issued<count and credit>0, where credit = 2 - buf_cnt - inflight + (out_valid && out_ready).
  - rom_en/rom_addr are combinational from registered state, plus the out_ready term via credit.
  - rom_addr = (base_addr + issued) mod 2**ADDR_WIDTH; wraps from all-ones to 0.
  - rom_addr holds its last value when rom_en=0.
- Latency: a read issued in cycle t returns rom_data in cycle t+1. It is written into the buffer at the end of cycle t+1 and appears on out_data/out_valid in cycle t+2 if the buffer was otherwise empty.
- inflight (0/1) marks that rom_data is valid this cycle. rom_data in any cycle with inflight=0 is ignored.
- Buffer: 2-entry FIFO, head drives out_data. The credit rule guarantees it never overflows.
  - Simultaneous write and pop is allowed.
  - out_data, out_last and out_valid hold stable while out_valid && !out_ready.
- Throughput: with out_ready held high, one word per cycle after the 2-cycle initial latency.
- out_last = out_valid && (popped == count-1).
- Widths: the issued and popped counters are ADDR_WIDTH+1 bits so count = 2**ADDR_WIDTH is representable. The address sum is truncated to ADDR_WIDTH.
- Reset mid-run: aborts immediately. Any in-flight ROM word is discarded, no done pulse is produced, and outputs take their reset values.

Test Plan:
- base=2, count=4, out_ready=1, start in cycle 0 -> rom_en cycles 1-4 with addr 2,3,4,5; out_valid cycles 3-6 with data=mem[2..5]; out_last in cycle 6 only; done in cycle 7; busy cycles 1-7.
- base=14, count=4 (ADDR_WIDTH=4) -> addresses 14,15,0,1; data mem[14],mem[15],mem[0],mem[1] in order; last on mem[1].
- base=0, count=8, out_ready low for cycles 3-9 -> at most 2 words buffered; out_data stable at mem[0] while stalled; no rom_en while credit=0; all 8 words delivered exactly once in order after release.
- count=0 -> no rom_en, no out_valid; done in cycle 1.
- count=16 with random out_ready (~50%) -> all 16 words mem[0..15] delivered, out_last only on the 16th; a start pulse mid-run is ignored.
- rst_n low mid-run after 3 words -> all outputs 0 immediately; a fresh run (base=5, count=2) after release delivers mem[5], mem[6] with no stale word.
